seq_bin_to_bcd: RTL

Multi-cycle shift-and-add-3 (double-dabble) converter from binary to packed BCD. It sits between the operand/product display-value register and display_controller in the keypad-multiplier top level. It replaces the combinational bin_to_bcd so the 8x8 product (up to 65025) fits timing at the 27 MHz system clock. It also emits a leading-zero blank mask and an overflow flag.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_adj.sv | 17 +
 rtl/seq_bin_to_bcd.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit type and the double-dabble add-3 constants.
package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t ADD3_THRESHOLD = 4'd5;
    localparam bcd_digit_t ADD3_VALUE     = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Ports: digit_i (digit before shift), digit_o (corrected digit).
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADD3_THRESHOLD) begin
            digit_o = digit_i + ADD3_VALUE;
        end
    end

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Multi-cycle shift-and-add-3 binary to packed BCD converter.
// Ports: clk, rst (sync, active-low), start/bin_in request, busy, done pulse,
// bcd_out (digit 0 in [3:0]), digit_valid (leading-zero mask), overflow.
module seq_bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]   digit_valid,
    output logic                overflow
);

    localparam int AW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [AW-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0] dv_q, dv_d;
    logic              ovo_q, ovo_d;
    logic              done_q, done_d;

    logic [AW-1:0]     acc_adj;
    logic [AW-1:0]     acc_sh;
    logic [WIDTH-1:0]  sh_sh;
    logic              carry;
    logic              ovf_fin;
    logic              nz_seen;
    logic [DIGITS-1:0] mask;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_i (acc_q[4*g +: 4]),
                .digit_o (acc_adj[4*g +: 4])
            );
        end
    endgenerate

    // The bit leaving the top digit means the value needs one more digit.
    always_comb begin
        {carry, acc_sh, sh_sh} = {1'b0, acc_adj, sh_q} << 1;
        ovf_fin = ovf_q | carry;
    end

    // Scan from the top digit down: once a nonzero digit is seen,
    // every lower digit is significant.
    always_comb begin
        nz_seen = 1'b0;
        mask    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nz_seen = nz_seen | (acc_sh[4*k +: 4] != 4'd0);
            mask[k] = nz_seen;
        end
        mask[0] = 1'b1;
        if (ovf_fin) begin
            mask = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        dv_d    = dv_q;
        ovo_d   = ovo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONVERT;
                    sh_d    = bin_in;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            CONVERT: begin
                acc_d = acc_sh;
                sh_d  = sh_sh;
                ovf_d = ovf_fin;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    bcd_d   = acc_sh;
                    dv_d    = mask;
                    ovo_d   = ovf_fin;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
            dv_q    <= DIGITS'(1);
            ovo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
            dv_q    <= dv_d;
            ovo_q   <= ovo_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == CONVERT);
    assign done        = done_q;
    assign bcd_out     = bcd_q;
    assign digit_valid = dv_q;
    assign overflow    = ovo_q;

endmodule
